ss_key_det: RTL

- Detects in-game-menu hotkeys and turns them into a request to the in-game menu sequencer.
- Snoops the cartridge's joypad port reads and assembles the 8-button pad state.
- Matches the pad state against the save/load/menu key codes from the configuration register file.
- Also accepts the external cartridge button.
- Issues a held request with a ready/ack handshake; sits between the config register file / IO snoop and the menu sequencer.

---
 rtl/ss_pkg.sv | 16 +
 rtl/ss_btn_deb.sv | 32 +++
 rtl/ss_key_det.sv | 112 +++++++++++
 3 files changed

// File: rtl/ss_pkg.sv
// ss_pkg: shared request codes, pad bit positions and FSM states for the hotkey detector.
package ss_pkg;
  localparam logic [1:0] SS_REQ_NONE = 2'd0;
  localparam logic [1:0] SS_REQ_SAVE = 2'd1;
  localparam logic [1:0] SS_REQ_LOAD = 2'd2;
  localparam logic [1:0] SS_REQ_MENU = 2'd3;
  localparam int PAD_U = 0;
  localparam int PAD_D = 1;
  localparam int PAD_L = 2;
  localparam int PAD_R = 3;
  localparam int PAD_B = 4;
  localparam int PAD_C = 5;
  localparam int PAD_A = 6;
  localparam int PAD_S = 7;
  typedef enum logic [1:0] {ST_IDLE, ST_COUNT, ST_REQ, ST_WAIT_REL} ss_state_e;
endpackage

// File: rtl/ss_btn_deb.sv
// ss_btn_deb: 2-flop synchroniser and debounce for an active-low button, with a press pulse.
module ss_btn_deb #(
  parameter int DEB_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n_i,
  output logic press_o,
  output logic held_o
);
  logic [1:0] sync_q;
  logic [DEB_W-1:0] cnt_q;
  logic deb_q, press_q, flip, full;
  assign flip = sync_q[1] != deb_q;
  assign full = &cnt_q;
  // the level is adopted only after 2^DEB_W consecutive cycles of disagreement
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      deb_q   <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], ~btn_n_i};
      cnt_q   <= (flip && !full) ? cnt_q + 1'b1 : '0;
      deb_q   <= (flip && full) ? sync_q[1] : deb_q;
      press_q <= flip && full && sync_q[1];
    end
  end
  assign press_o = press_q;
  assign held_o  = deb_q;
endmodule

// File: rtl/ss_key_det.sv
// ss_key_det: assembles the joypad state from port snoops, matches hotkeys and
// issues a held save/load/menu request with ready/ack handshake.
module ss_key_det #(
  parameter int HOLD_N = 3,
  parameter int DEB_W  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] key_save,
  input  logic [7:0] key_load,
  input  logic [7:0] key_menu,
  input  logic       ct_ss_on,
  input  logic       ct_ss_btn,
  input  logic       joy_rd_stb,
  input  logic       joy_th,
  input  logic [5:0] joy_dat,
  input  logic       ss_btn,
  output logic [7:0] pad,
  output logic       pad_upd,
  output logic       req_vld,
  output logic [1:0] req_code,
  input  logic       req_ack
);
  import ss_pkg::*;
  localparam logic [3:0] HOLD_C = 4'(HOLD_N);
  logic [5:0] hi_q;
  logic [1:0] lo_q;
  logic got_hi_q, got_lo_q, upd_q, vld_q, btn_src_q;
  logic [7:0] pad_q;
  ss_state_e state_q;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] code_q, hit;
  logic pub, hi_ok, lo_ok, press, held, btn_evt;
  ss_btn_deb #(.DEB_W(DEB_W)) u_btn (
    .clk(clk), .rst(rst), .btn_n_i(ss_btn), .press_o(press), .held_o(held)
  );
  always_comb begin
    pub     = got_hi_q & got_lo_q;
    hi_ok   = joy_rd_stb & joy_th;
    lo_ok   = joy_rd_stb & ~joy_th & (joy_dat[3:2] == 2'b00);
    hit     = (key_menu != 8'h00 && pad_q == key_menu) ? SS_REQ_MENU :
              (key_save != 8'h00 && pad_q == key_save) ? SS_REQ_SAVE :
              (key_load != 8'h00 && pad_q == key_load) ? SS_REQ_LOAD : SS_REQ_NONE;
    cnt_d   = (state_q == ST_COUNT && hit == code_q) ? cnt_q + 4'd1 : 4'd1;
    btn_evt = press & ct_ss_btn;
  end
  // a strobe landing on the publish edge re-arms its flag for the following pad
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      hi_q     <= '0;
      lo_q     <= '0;
      got_hi_q <= 1'b0;
      got_lo_q <= 1'b0;
      pad_q    <= '0;
      upd_q    <= 1'b0;
    end else begin
      upd_q    <= pub;
      pad_q    <= pub ? {lo_q, hi_q} : pad_q;
      got_hi_q <= hi_ok | (got_hi_q & ~pub);
      got_lo_q <= lo_ok | (got_lo_q & ~pub);
      hi_q     <= hi_ok ? ~joy_dat : hi_q;
      lo_q     <= lo_ok ? ~joy_dat[5:4] : lo_q;
    end
  end
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      code_q    <= SS_REQ_NONE;
      vld_q     <= 1'b0;
      btn_src_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_COUNT: begin
          if (btn_evt) begin
            state_q   <= ST_REQ;
            code_q    <= SS_REQ_MENU;
            vld_q     <= 1'b1;
            btn_src_q <= 1'b1;
          end else if (!ct_ss_on) begin
            state_q <= ST_IDLE;
          end else if (upd_q) begin
            if (hit == SS_REQ_NONE) begin
              state_q <= ST_IDLE;
            end else begin
              code_q    <= hit;
              cnt_q     <= cnt_d;
              btn_src_q <= 1'b0;
              vld_q     <= cnt_d == HOLD_C;
              state_q   <= (cnt_d == HOLD_C) ? ST_REQ : ST_COUNT;
            end
          end
        end
        // only a button-originated request survives the master enable dropping
        ST_REQ: begin
          if (req_ack || (!ct_ss_on && !btn_src_q)) begin
            vld_q   <= 1'b0;
            state_q <= ct_ss_on ? ST_WAIT_REL : ST_IDLE;
          end
        end
        ST_WAIT_REL: begin
          if (!ct_ss_on || (upd_q && pad_q == 8'h00 && !held)) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
  assign pad      = pad_q;
  assign pad_upd  = upd_q;
  assign req_vld  = vld_q;
  assign req_code = vld_q ? code_q : SS_REQ_NONE;
endmodule
